// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if
// Bundles the fetch-stage signals between the PC, the instruction ROM, the
// fetch queue and decode.
//   master : the fetch queue (drives ROM request, stall and the decode head)
//   slave  : the surrounding pipeline (PC, ROM and decode)
// Signals:
//   pc, pc_valid, pc_stall     - PC word address, its valid flag, hold request
//   flush                      - redirect, discards queued and in-flight fetches
//   imem_en, imem_addr         - ROM read request
//   imem_rdata                 - ROM data, one cycle after imem_en
//   instr, instr_pc            - head instruction and its address
//   instr_valid, instr_ready   - decode handshake
//   occupancy                  - number of valid queue entries
interface instr_fetch_queue_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic              pc_stall;
   logic              flush;
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [OCC_W-1:0]  occupancy;

   modport master (
      input  pc, pc_valid, flush, imem_rdata, instr_ready,
      output pc_stall, imem_en, imem_addr, instr, instr_pc, instr_valid, occupancy
   );

   modport slave (
      output pc, pc_valid, flush, imem_rdata, instr_ready,
      input  pc_stall, imem_en, imem_addr, instr, instr_pc, instr_valid, occupancy
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Fetch stage between the PC and decode. Issues reads to a synchronous
// instruction ROM and buffers returned words with their addresses in a
// DEPTH-entry circular queue drained by decode through valid/ready.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high; clears all state including storage
//   bus   - instr_fetch_queue_if master modport (PC, ROM and decode signals)
module instr_fetch_queue #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input logic               clk,
   input logic               reset,
   instr_fetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W:0] DEPTH_SUM = (OCC_W+1)'(DEPTH);

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              inflight_v_q, inflight_v_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

   logic [DATA_W-1:0] instr_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

   logic stall;
   logic req;
   logic push;
   logic pop;

   // The in-flight fetch reserves a slot, so a request is only allowed while
   // queued plus outstanding words leave room for one more.
   assign stall = reset | (({1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_v_q}) >= DEPTH_SUM);
   assign req   = bus.pc_valid & ~stall & ~bus.flush & ~reset;
   // A word returning during a flush belongs to a killed fetch.
   assign push  = inflight_v_q & ~bus.flush;
   assign pop   = bus.instr_valid & bus.instr_ready & ~bus.flush;

   assign bus.pc_stall    = stall;
   assign bus.imem_en     = req;
   assign bus.imem_addr   = bus.pc;
   assign bus.instr_valid = (occ_q != '0);
   assign bus.instr       = instr_mem_q[head_q];
   assign bus.instr_pc    = pc_mem_q[head_q];
   assign bus.occupancy   = occ_q;

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      occ_d         = occ_q;
      inflight_v_d  = req;
      inflight_pc_d = bus.pc;
      if (bus.flush) begin
         head_d       = '0;
         tail_d       = '0;
         occ_d        = '0;
         inflight_v_d = 1'b0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q        <= '0;
         tail_q        <= '0;
         occ_q         <= '0;
         inflight_v_q  <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         occ_q         <= occ_d;
         inflight_v_q  <= inflight_v_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // One write port per entry, selected by the tail pointer.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (reset) begin
            instr_mem_q[gi] <= '0;
            pc_mem_q[gi]    <= '0;
         end else if (push && (tail_q == PTR_W'(gi))) begin
            instr_mem_q[gi] <= bus.imem_rdata;
            pc_mem_q[gi]    <= inflight_pc_q;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
   typedef struct {
      logic [31:0] instr;
      logic [9:0]  pc;
      int          cyc;
      bit          exact;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   int   cyc;
   int   n_acc;
   bit   exact_mode;
   bit   exact_next;
   logic [9:0] pc_r;
   exp_t sb[$];

   logic       s_stall, s_valid, s_en;
   logic [2:0] s_occ;
   logic [31:0] s_instr;
   logic [9:0]  s_ipc;

   instr_fetch_queue_if #(.ADDR_W(10), .DATA_W(32), .DEPTH(4)) bus ();

   instr_fetch_queue #(.ADDR_W(10), .DATA_W(32), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM: word n = 0x1000_0000 + n
   always @(posedge clk)
      if (bus.imem_en) bus.imem_rdata <= 32'h1000_0000 + {22'b0, bus.imem_addr};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle of stimulus; the PC model advances only on acceptance.
   task automatic cycle(input bit rst, input bit pv, input bit rdy, input bit fl, input int redir);
      exp_t e;
      bit   acc;
      reset           = rst;
      bus.pc_valid    = pv;
      bus.instr_ready = rdy;
      bus.flush       = fl;
      bus.pc          = pc_r;
      @(negedge clk);
      s_stall = bus.pc_stall;
      s_occ   = bus.occupancy;
      s_valid = bus.instr_valid;
      s_en    = bus.imem_en;
      s_instr = bus.instr;
      s_ipc   = bus.instr_pc;
      acc = pv && !bus.pc_stall && !fl && !rst;
      chk("imem_en", bus.imem_en, acc);
      if (acc) begin
         chk("imem_addr", bus.imem_addr, pc_r);
         e.instr = 32'h1000_0000 + {22'b0, pc_r};
         e.pc    = pc_r;
         e.cyc   = cyc;
         e.exact = exact_mode || exact_next;
         exact_next = 1'b0;
         sb.push_back(e);
         n_acc++;
      end
      if (fl || rst) sb.delete();
      @(posedge clk);
      #1;
      if (acc) pc_r = pc_r + 10'd1;
      if (fl)  pc_r = 10'(redir);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 30 && sb.size() != 0; i++) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      chk("drain_empty", sb.size(), 0);
      chk("drain_valid", s_valid, 0);
      chk("drain_occ", s_occ, 0);
   endtask

   // Monitor: pops the scoreboard for every accepted head.
   logic        hold_q;
   logic [31:0] held_instr;
   logic [9:0]  held_pc;
   exp_t        me;
   initial hold_q = 1'b0;
   always @(negedge clk) begin
      if (!reset && !bus.flush) begin
         if (hold_q && bus.instr_valid) begin
            chk("stable_instr", bus.instr, held_instr);
            chk("stable_pc", bus.instr_pc, held_pc);
         end
         if (bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               me = sb.pop_front();
               chk("instr", bus.instr, me.instr);
               chk("instr_pc", bus.instr_pc, me.pc);
               chk("latency_min", (cyc - me.cyc) >= 2, 1);
               if (me.exact) chk("latency_exact", cyc - me.cyc, 2);
               $display("deliver pc=%0d instr=%08h cycle=%0d", bus.instr_pc, bus.instr, cyc);
            end
         end
      end
      hold_q     = bus.instr_valid && !bus.instr_ready && !bus.flush && !reset;
      held_instr = bus.instr;
      held_pc    = bus.instr_pc;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0; n_acc = 0;
      exact_mode = 0; exact_next = 0;
      pc_r = 10'd0;
      reset = 1'b1; bus.pc_valid = 1'b1; bus.instr_ready = 1'b1;
      bus.flush = 1'b0; bus.pc = 10'd0;

      // Reset during traffic
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_occ", s_occ, 0);
      chk("rst_en", s_en, 0);
      chk("rst_stall", s_stall, 1);
      chk("rst_instr", s_instr, 0);
      chk("rst_ipc", s_ipc, 0);

      // Streaming 0..4
      exact_mode = 1;
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 0, 0);
         chk("stream_stall", s_stall, 0);
         chk("stream_occ_le1", s_occ <= 3'd1, 1);
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      exact_mode = 0;

      // Back-pressure: fetch from 5 with decode blocked
      n_acc = 0;
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
      chk("bp_accepts", n_acc, 4);
      chk("bp_stall", s_stall, 1);
      chk("bp_occ", s_occ, 4);
      chk("bp_head_pc", s_ipc, 5);
      cycle(0, 1, 1, 0, 0);
      chk("release_stall_hold", s_stall, 1);
      cycle(0, 1, 1, 0, 0);
      chk("release_stall_fall", s_stall, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);
      drain();

      // Pointer wrap-around: 20 fetches, ready 1 high / 2 low
      pc_r = 10'd0;
      n_acc = 0;
      for (int i = 0; i < 300 && n_acc < 20; i++) cycle(0, 1, (i % 3) == 0, 0, 0);
      chk("wrap_accepts", n_acc, 20);
      drain();

      // Mid-operation reset
      pc_r = 10'd30;
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      chk("midrst_valid", s_valid, 0);
      chk("midrst_occ", s_occ, 0);
      chk("midrst_en", s_en, 0);
      chk("midrst_stall", s_stall, 1);
      cycle(0, 1, 1, 0, 0);
      chk("postrst_stall", s_stall, 0);
      chk("postrst_valid", s_valid, 0);
      for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0);
      drain();

      // Flush while full, redirect to 24
      pc_r = 10'd50;
      n_acc = 0;
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      chk("flfull_accepts", n_acc, 4);
      cycle(0, 1, 0, 1, 24);
      chk("flfull_occ_pre", s_occ, 3);
      chk("flfull_stall_pre", s_stall, 1);
      exact_next = 1;
      cycle(0, 1, 1, 0, 0);
      chk("flfull_occ_post", s_occ, 0);
      chk("flfull_valid_post", s_valid, 0);
      chk("flfull_req_post", s_en, 1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
      drain();

      // Flush in the same cycle as a pop, redirect to 12
      pc_r = 10'd60;
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 1, 1, 12);
      chk("flpop_valid_pre", s_valid, 1);
      chk("flpop_head_pre", s_ipc, 60);
      exact_next = 1;
      cycle(0, 1, 1, 0, 0);
      chk("flpop_valid_post", s_valid, 0);
      chk("flpop_occ_post", s_occ, 0);
      for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
